ifetch_unit: RTL

//  Instruction-fetch front end: owns the architectural PC register and consumes the next-PC selection (redirects).

---
 rtl/mips_pkg.sv | 23 ++
 rtl/ifetch_unit_if.sv | 30 +++
 rtl/ifetch_unit_buf.sv | 63 ++++++
 rtl/ifetch_unit.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch-path constants, fetch FSM states and fetch-buffer entry type
// Purpose : widths, reset vector default, fetch FSM state enum and the
//           {inst, pc, pc4} entry carried through the fetch buffer.
// Ports   : none (package).
package mips_pkg;

  localparam int          XLEN         = 32;
  localparam int          ILEN         = 32;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - instruction-memory and decode-side bundles of the fetch unit
// Purpose : imem_if groups the req/gnt/rvalid read channel, inst_if groups
//           the valid/ready instruction channel towards decode.
// Ports   : imem_if  master drives req, addr; slave drives gnt, rvalid, rdata.
//           inst_if  master drives valid, data, pc, pc4; slave drives ready.
interface imem_if;
  import mips_pkg::*;

  logic            req;
  logic [XLEN-1:0] addr;
  logic            gnt;
  logic            rvalid;
  logic [ILEN-1:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

interface inst_if;
  import mips_pkg::*;

  logic            valid;
  logic            ready;
  logic [ILEN-1:0] data;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc4;

  modport master (output valid, data, pc, pc4, input ready);
  modport slave  (input valid, data, pc, pc4, output ready);
endinterface

// File: rtl/ifetch_unit_buf.sv
// rtl/ifetch_unit_buf.sv - fetch buffer: synchronous FIFO with flush, count and push/pop in one cycle
// Purpose : holds returned instruction words with their PC until decode takes them.
// Ports   : clk, rst      clock, asynchronous active-high reset
//           flush         empties the buffer (wins over push/pop)
//           push, push_entry   write one entry (accepted when not full, or full with pop)
//           pop           remove head (ignored when empty)
//           head, empty, count  head entry, empty flag, number of entries
module ifetch_buf
  import mips_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch front end: PC register, imem read FSM, redirects, fetch buffer
// Purpose : owns the fetch PC, issues one word read at a time to instruction
//           memory, buffers returned words and hands {inst, pc, pc4} to decode.
// Ports   : clk, rst                     clock, asynchronous active-high reset
//           redirect_valid, redirect_pc  one-cycle redirect pulse and target
//           imem (imem_if.master)        req/addr out, gnt/rvalid/rdata in
//           inst (inst_if.master)        valid/data/pc/pc4 out, ready in
//           fetch_misalign, misalign_pc  only with IFETCH_ALIGN_CHECK_EN defined
// Build   : IFETCH_ALIGN_CHECK_EN defined  misaligned redirects halt fetch and are reported.
//           IFETCH_ALIGN_CHECK_EN undefined redirect_pc[1:0] is forced to 2'b00.
module ifetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_VECTOR,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  imem_if.master          imem,
  inst_if.master          inst
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic            fetch_misalign,
  output logic [XLEN-1:0] misalign_pc
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            idle_q, idle_d;
  logic            req_int;
  logic            fire;
  logic            push;
  logic            halt;
  logic [XLEN-1:0] target_pc;
  logic [CW-1:0]   buf_count;
  logic            buf_empty;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

`ifdef IFETCH_ALIGN_CHECK_EN
  logic            misalign_q;
  logic [XLEN-1:0] misalign_pc_q;
  logic            redirect_bad;

  assign redirect_bad = redirect_pc[1:0] != 2'b00;
  assign target_pc    = redirect_pc;

  // Sticky until the next redirect; an aligned redirect clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q    <= 1'b0;
      misalign_pc_q <= '0;
    end else if (redirect_valid) begin
      misalign_q    <= redirect_bad;
      misalign_pc_q <= redirect_bad ? redirect_pc : '0;
    end
  end

  assign halt           = misalign_q;
  assign fetch_misalign = misalign_q;
  assign misalign_pc    = misalign_pc_q;
`else
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign target_pc           = {redirect_pc[XLEN-1:2], 2'b00};
  assign halt                = 1'b0;
`endif

  // In REQ nothing is outstanding, so the buffer count alone is the credit.
  // idle_q holds the request low for the cycle after an abandoned request.
  assign req_int  = (state_q == FETCH_REQ) && (buf_count < CW'(FIFO_DEPTH)) && !idle_q && !halt;
  assign fire     = req_int && imem.gnt;
  assign imem.req  = req_int && !rst;
  assign imem.addr = pc_q;

  // pc_q already advanced at grant, so the outstanding word's PC is pc_q-4.
  assign push_entry = '{inst: imem.rdata, pc: pc_q - 32'd4, pc4: pc_q};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    idle_d  = 1'b0;
    push    = 1'b0;
    case (state_q)
      FETCH_REQ: begin
        if (fire) begin
          pc_d    = pc_q + 32'd4;
          state_d = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem.rvalid) begin
          push    = 1'b1;
          state_d = FETCH_REQ;
        end
      end
      FETCH_DROP: begin
        if (imem.rvalid) state_d = FETCH_REQ;
      end
      default: state_d = FETCH_REQ;
    endcase

    // A redirect overrides the normal transition; any read still in flight
    // must be drained through DROP so its data never reaches the buffer.
    if (redirect_valid) begin
      push = 1'b0;
      pc_d = target_pc;
      if (state_q == FETCH_REQ) begin
        state_d = fire ? FETCH_DROP : FETCH_REQ;
        idle_d  = !fire;
      end else begin
        state_d = imem.rvalid ? FETCH_REQ : FETCH_DROP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH_REQ;
      pc_q    <= RESET_PC;
      idle_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      idle_q  <= idle_d;
    end
  end

  ifetch_buf #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (inst.ready),
    .head       (head),
    .empty      (buf_empty),
    .count      (buf_count)
  );

  assign inst.valid = !buf_empty;
  assign inst.data  = head.inst;
  assign inst.pc    = head.pc;
  assign inst.pc4   = head.pc4;

endmodule
